// File: rtl/router_reg_if.sv
// Bundle of the router register stage's signals: source byte, FIFO status, FSM strobes, and the register outputs.
// The FSM/source side uses the master modport; the register stage uses the slave modport.
interface router_reg_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  pkt_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  fifo_full;
  logic                  detect_add;
  logic                  lfd_state;
  logic                  ld_state;
  logic                  laf_state;
  logic                  full_state;
  logic                  rst_int_reg;
  logic [DATA_WIDTH-1:0] dout;
  logic                  parity_done;
  logic                  low_pkt_valid;
  logic                  err;

  modport master (
    output pkt_valid, data_in, fifo_full,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    input  dout, parity_done, low_pkt_valid, err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_pkt_valid, err
  );
endinterface

// File: rtl/router_reg.sv
// Datapath register stage of the 1x3 router: header capture, byte parking while the FIFO is full,
// running XOR parity and parity-error reporting back to the control FSM.
module router_reg #(
  parameter int DATA_WIDTH = 8
) (
  input logic         clock,
  input logic         reset,
  router_reg_if.slave bus
);

  logic [DATA_WIDTH-1:0] header_byte;
  logic [DATA_WIDTH-1:0] full_byte;
  logic [DATA_WIDTH-1:0] internal_parity;
  logic [DATA_WIDTH-1:0] packet_parity;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] dout_next;
  logic                  parity_done_q;
  logic                  low_pkt_valid_q;
  logic                  err_q;

  // Address 2'b11 does not exist on a 1x3 router, so such a header is never captured.
  logic header_load;
  assign header_load = bus.detect_add && bus.pkt_valid && (bus.data_in[1:0] != 2'b11);

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    dout_next = dout_q;
    if (bus.lfd_state)
      dout_next = header_byte;
    else if (bus.ld_state && !bus.fifo_full)
      dout_next = bus.data_in;
    else if (bus.laf_state)
      dout_next = full_byte;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      dout_q      <= '0;
      header_byte <= '0;
      full_byte   <= '0;
    end else begin
      dout_q <= dout_next;
      if (header_load)
        header_byte <= bus.data_in;
      if (bus.ld_state && bus.fifo_full)
        full_byte <= bus.data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      low_pkt_valid_q <= 1'b0;
    else if (bus.rst_int_reg)
      low_pkt_valid_q <= 1'b0;
    else if (bus.ld_state && !bus.pkt_valid)
      low_pkt_valid_q <= 1'b1;
  end

  // A byte parked in full_byte is folded in when it arrives; full_state blocks a second XOR of the held byte.
  always_ff @(posedge clock) begin
    if (reset)
      internal_parity <= '0;
    else if (bus.detect_add)
      internal_parity <= '0;
    else if (bus.lfd_state)
      internal_parity <= internal_parity ^ header_byte;
    else if (bus.ld_state && bus.pkt_valid && !bus.full_state)
      internal_parity <= internal_parity ^ bus.data_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      packet_parity <= '0;
      parity_done_q <= 1'b0;
    end else if (bus.detect_add) begin
      packet_parity <= '0;
      parity_done_q <= 1'b0;
    end else if (bus.ld_state && !bus.pkt_valid && !bus.fifo_full) begin
      packet_parity <= bus.data_in;
      parity_done_q <= 1'b1;
    end else if (bus.laf_state && low_pkt_valid_q && !parity_done_q) begin
      packet_parity <= full_byte;
      parity_done_q <= 1'b1;
    end
  end

  // err compares one edge after parity_done rises, then keeps re-evaluating the same stable values.
  always_ff @(posedge clock) begin
    if (reset)
      err_q <= 1'b0;
    else if (bus.detect_add)
      err_q <= 1'b0;
    else if (parity_done_q)
      err_q <= (internal_parity != packet_parity);
  end

  assign bus.dout          = dout_q;
  assign bus.parity_done   = parity_done_q;
  assign bus.low_pkt_valid = low_pkt_valid_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: drives FSM strobes cycle by cycle and checks outputs against hand-computed values.
module tb_router_reg;

  localparam int DW = 8;

  // Strobe vector order: {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg}
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_DA   = 6'b100000;
  localparam logic [5:0] S_LFD  = 6'b010000;
  localparam logic [5:0] S_LD   = 6'b001000;
  localparam logic [5:0] S_LAF  = 6'b000100;
  localparam logic [5:0] S_FULL = 6'b000010;
  localparam logic [5:0] S_RIR  = 6'b000001;

  logic clock;
  logic reset;
  int   n_pass;
  int   n_total;

  router_reg_if #(.DATA_WIDTH(DW)) rif ();

  router_reg #(.DATA_WIDTH(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (rif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic check_outs(input string tag, input logic [DW-1:0] d, input logic pd,
                            input logic lpv, input logic e);
    check({tag, ".dout"}, rif.dout, d);
    check({tag, ".parity_done"}, {7'd0, rif.parity_done}, {7'd0, pd});
    check({tag, ".low_pkt_valid"}, {7'd0, rif.low_pkt_valid}, {7'd0, lpv});
    check({tag, ".err"}, {7'd0, rif.err}, {7'd0, e});
  endtask

  // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic [5:0] st, input logic pv, input logic [DW-1:0] din, input logic ff);
    @(negedge clock);
    {rif.detect_add, rif.lfd_state, rif.ld_state, rif.laf_state, rif.full_state, rif.rst_int_reg} = st;
    rif.pkt_valid = pv;
    rif.data_in   = din;
    rif.fifo_full = ff;
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    {rif.detect_add, rif.lfd_state, rif.ld_state, rif.laf_state, rif.full_state, rif.rst_int_reg} = S_NONE;
    rif.pkt_valid = 1'b0;
    rif.data_in   = 8'hAA;
    rif.fifo_full = 1'b0;
    step(S_NONE, 1'b0, 8'hAA, 1'b0);
    step(S_NONE, 1'b0, 8'hAA, 1'b0);
    check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Normal packet: header 0C, payload 11 22 33, parity 0C.
    step(S_DA,  1'b1, 8'h0C, 1'b0);
    step(S_LFD, 1'b1, 8'h11, 1'b0);
    check("norm.hdr", rif.dout, 8'h0C);
    step(S_LD,  1'b1, 8'h11, 1'b0);
    check("norm.p1", rif.dout, 8'h11);
    step(S_LD,  1'b1, 8'h22, 1'b0);
    check("norm.p2", rif.dout, 8'h22);
    step(S_LD,  1'b1, 8'h33, 1'b0);
    check("norm.p3", rif.dout, 8'h33);
    step(S_LD,  1'b0, 8'h0C, 1'b0);
    check_outs("norm.par", 8'h0C, 1'b1, 1'b1, 1'b0);
    step(S_NONE, 1'b0, 8'h00, 1'b0);
    check_outs("norm.chk", 8'h0C, 1'b1, 1'b1, 1'b0);
    step(S_RIR, 1'b0, 8'h00, 1'b0);
    check_outs("norm.rir", 8'h0C, 1'b1, 1'b0, 1'b0);

    // Bad parity: parity byte FF instead of 0C.
    step(S_DA,  1'b1, 8'h0C, 1'b0);
    check_outs("bad.da", 8'h0C, 1'b0, 1'b0, 1'b0);
    step(S_LFD, 1'b1, 8'h11, 1'b0);
    step(S_LD,  1'b1, 8'h11, 1'b0);
    step(S_LD,  1'b1, 8'h22, 1'b0);
    step(S_LD,  1'b1, 8'h33, 1'b0);
    step(S_LD,  1'b0, 8'hFF, 1'b0);
    check_outs("bad.par", 8'hFF, 1'b1, 1'b1, 1'b0);
    step(S_NONE, 1'b0, 8'h00, 1'b0);
    check("bad.err", {7'd0, rif.err}, 8'h01);
    step(S_RIR, 1'b0, 8'h00, 1'b0);
    check("bad.err_hold", {7'd0, rif.err}, 8'h01);
    step(S_NONE, 1'b0, 8'h00, 1'b0);
    check("bad.err_hold2", {7'd0, rif.err}, 8'h01);

    // FIFO full mid-payload: 22 parked while the FIFO is full.
    step(S_DA,  1'b1, 8'h0C, 1'b0);
    check("ff.err_clr", {7'd0, rif.err}, 8'h00);
    step(S_LFD, 1'b1, 8'h11, 1'b0);
    step(S_LD,  1'b1, 8'h11, 1'b0);
    step(S_LD,  1'b1, 8'h22, 1'b1);
    check("ff.park_dout", rif.dout, 8'h11);
    step(S_FULL, 1'b1, 8'h22, 1'b1);
    check("ff.stall_dout", rif.dout, 8'h11);
    step(S_LAF, 1'b1, 8'h22, 1'b0);
    check("ff.laf_dout", rif.dout, 8'h22);
    step(S_LD,  1'b1, 8'h33, 1'b0);
    step(S_LD,  1'b0, 8'h0C, 1'b0);
    check_outs("ff.par", 8'h0C, 1'b1, 1'b1, 1'b0);
    step(S_NONE, 1'b0, 8'h00, 1'b0);
    check("ff.err", {7'd0, rif.err}, 8'h00);
    step(S_RIR, 1'b0, 8'h00, 1'b0);

    // FIFO full on the parity byte.
    step(S_DA,  1'b1, 8'h0C, 1'b0);
    step(S_LFD, 1'b1, 8'h11, 1'b0);
    step(S_LD,  1'b1, 8'h11, 1'b0);
    step(S_LD,  1'b1, 8'h22, 1'b0);
    step(S_LD,  1'b1, 8'h33, 1'b0);
    step(S_LD,  1'b0, 8'h0C, 1'b1);
    check_outs("ffp.park", 8'h33, 1'b0, 1'b1, 1'b0);
    step(S_FULL, 1'b0, 8'h0C, 1'b1);
    check_outs("ffp.stall", 8'h33, 1'b0, 1'b1, 1'b0);
    step(S_LAF, 1'b0, 8'h0C, 1'b0);
    check_outs("ffp.laf", 8'h0C, 1'b1, 1'b1, 1'b0);
    step(S_NONE, 1'b0, 8'h00, 1'b0);
    check("ffp.err", {7'd0, rif.err}, 8'h00);
    step(S_RIR, 1'b0, 8'h00, 1'b0);

    // Invalid address 11 must not overwrite the header; pkt_valid low must not load either.
    step(S_DA,  1'b1, 8'h07, 1'b0);
    step(S_LFD, 1'b1, 8'h00, 1'b0);
    check("inv.hdr", rif.dout, 8'h0C);
    step(S_DA,  1'b1, 8'h0D, 1'b0);
    step(S_LFD, 1'b1, 8'h00, 1'b0);
    check("valid.hdr", rif.dout, 8'h0D);
    step(S_DA,  1'b0, 8'h0E, 1'b0);
    step(S_LFD, 1'b1, 8'h00, 1'b0);
    check("nopv.hdr", rif.dout, 8'h0D);

    // Reset during the second payload byte.
    step(S_DA,  1'b1, 8'h0C, 1'b0);
    step(S_LFD, 1'b1, 8'h11, 1'b0);
    step(S_LD,  1'b1, 8'h11, 1'b0);
    reset = 1'b1;
    step(S_LD,  1'b0, 8'h22, 1'b0);
    check_outs("rst.mid", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(S_LFD, 1'b1, 8'h00, 1'b0);
    check("rst.hdr_clr", rif.dout, 8'h00);

    // Clean packet after reset: header 0D, payload 01 02, parity 0D^01^02 = 0E.
    step(S_DA,  1'b1, 8'h0D, 1'b0);
    step(S_LFD, 1'b1, 8'h01, 1'b0);
    check("post.hdr", rif.dout, 8'h0D);
    step(S_LD,  1'b1, 8'h01, 1'b0);
    step(S_LD,  1'b1, 8'h02, 1'b0);
    step(S_LD,  1'b0, 8'h0E, 1'b0);
    check_outs("post.par", 8'h0E, 1'b1, 1'b1, 1'b0);
    step(S_NONE, 1'b0, 8'h00, 1'b0);
    check("post.err", {7'd0, rif.err}, 8'h00);
    step(S_RIR, 1'b0, 8'h00, 1'b0);
    check("post.lpv_clr", {7'd0, rif.low_pkt_valid}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
